rx_port: RTL and testbench

//  Receive side of one NoC router port. Accepts flits from an upstream link on a 2-phase req/ack channel.

---
 rtl/noc_pkg.sv | 17 +
 rtl/rx_buffer.sv | 33 +++
 rtl/rx_port.sv | 127 ++++++++++++
 tb/tb_rx_port.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router constants and the rx port state encoding.
package noc_pkg;

  localparam int unsigned FLIT_W   = 8;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned CHNL_W   = 3;
  localparam int unsigned HEAD_BIT = FLIT_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    ARB  = 2'd2,
    SEND = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_buffer.sv
// Packet flit buffer: DEPTH x FLIT_W register file.
// It has one synchronous write port and one asynchronous read port.
// Contents are not reset.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : mem[raddr], combinational
module rx_buffer
  import noc_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [FLIT_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [FLIT_W-1:0] rdata
);

  logic [FLIT_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_port.sv
// Receive side of one NoC router port.
// Flits arrive on a 2-phase req/ack link. One packet of DEPTH flits is
// buffered, with the head flit always stored at address 0. Once the packet
// is complete, the port requests the switch for the output channel carried
// in the head flit. The granted tx port then reads the buffer through
// buf_addr/buf_data.
// Optional feature: define RX_SYNC_EN to pass ch_req through a 2-flop
// synchronizer. The flit-to-ack latency then becomes 3 clk instead of 1.
//   clk, reset : clock, synchronous active-high reset
//   ch_req     : link request, toggles once per flit
//   ch_flit    : link flit data
//   ch_ack     : link ack, toggled when a flit is taken
//   sw_req     : switch request (level)
//   sw_chnl    : requested output channel
//   sw_gnt     : switch grant (level, held for the whole transfer)
//   buf_addr   : tx read address
//   buf_data   : buffer read data
module rx_port
  import noc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ch_req,
  input  logic [FLIT_W-1:0] ch_flit,
  output logic              ch_ack,
  output logic              sw_req,
  output logic [CHNL_W-1:0] sw_chnl,
  input  logic              sw_gnt,
  input  logic [ADDR_W-1:0] buf_addr,
  output logic [FLIT_W-1:0] buf_data
);

  logic              req_s;
  logic [FLIT_W-1:0] flit_s;
  rx_state_e         state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              pending_c;
  logic              take_c;
  logic              store_c;

`ifdef RX_SYNC_EN
  logic              req_m;
  logic              req_q;
  logic [FLIT_W-1:0] flit_q;

  // Two-flop request synchronizer. The flit is held by the sender until it
  // is acked, so it is sampled alongside the synchronized request.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_m  <= 1'b0;
      req_q  <= 1'b0;
      flit_q <= '0;
    end else begin
      req_m  <= ch_req;
      req_q  <= req_m;
      flit_q <= ch_flit;
    end
  end

  assign req_s  = req_q;
  assign flit_s = flit_q;
`else
  assign req_s  = ch_req;
  assign flit_s = ch_flit;
`endif

  // A flit is pending while the request phase differs from the ack phase.
  assign pending_c = req_s ^ ch_ack;
  assign take_c    = pending_c && ((state == IDLE) || (state == RECV));
  // In IDLE only a head flit is stored. Any other flit is acked and dropped.
  assign store_c   = take_c && ((state == RECV) || flit_s[HEAD_BIT]);

  rx_buffer u_buf (
    .clk   (clk),
    .we    (store_c),
    .waddr (wr_ptr),
    .wdata (flit_s),
    .raddr (buf_addr),
    .rdata (buf_data)
  );

  // Port FSM with ack toggle and write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ch_ack  <= 1'b0;
      sw_req  <= 1'b0;
      sw_chnl <= '0;
      wr_ptr  <= '0;
    end else begin
      if (take_c) begin
        ch_ack <= ~ch_ack;
      end
      // wr_ptr wraps to 0 after the last entry, so the next head lands at 0.
      if (store_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      case (state)
        IDLE: begin
          if (store_c) begin
            sw_chnl <= flit_s[CHNL_W-1:0];
            state   <= RECV;
          end
        end
        RECV: begin
          if (store_c && (wr_ptr == ADDR_W'(DEPTH - 1))) begin
            sw_req <= 1'b1;
            state  <= ARB;
          end
        end
        ARB: begin
          if (sw_gnt) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (!sw_gnt) begin
            sw_req <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_port.sv
module tb_rx_port;

`ifdef RX_SYNC_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif
  localparam int TIMEOUT = 20;
  localparam int NVEC    = 28;

  logic       clk = 1'b0;
  logic       reset;
  logic       ch_req;
  logic [7:0] ch_flit;
  logic       ch_ack;
  logic       sw_req;
  logic [2:0] sw_chnl;
  logic       sw_gnt;
  logic [2:0] buf_addr;
  logic [7:0] buf_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] flit;
    logic       exp_req;
    logic [2:0] exp_chnl;
  } vec_t;

  vec_t tbl [NVEC];

  rx_port dut (
    .clk      (clk),
    .reset    (reset),
    .ch_req   (ch_req),
    .ch_flit  (ch_flit),
    .ch_ack   (ch_ack),
    .sw_req   (sw_req),
    .sw_chnl  (sw_chnl),
    .sw_gnt   (sw_gnt),
    .buf_addr (buf_addr),
    .buf_data (buf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Toggle the request with a new flit and wait, bounded, for the ack.
  task automatic send_flit(input logic [7:0] f, output int lat);
    ch_flit = f;
    ch_req  = ~ch_req;
    lat = 0;
    while ((ch_ack !== ch_req) && (lat < TIMEOUT)) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int lat;
    for (int i = lo; i <= hi; i++) begin
      send_flit(tbl[i].flit, lat);
      check($sformatf("ack_lat[%0d]", i), 32'(lat), 32'(EXP_LAT));
      check($sformatf("sw_req[%0d]", i), 32'(sw_req), 32'(tbl[i].exp_req));
      check($sformatf("sw_chnl[%0d]", i), 32'(sw_chnl), 32'(tbl[i].exp_chnl));
    end
  endtask

  task automatic read_buf(input int lo, input string tag);
    for (int a = 0; a < 8; a++) begin
      buf_addr = 3'(a);
      #1;
      check($sformatf("%s_buf[%0d]", tag, a), 32'(buf_data), 32'(tbl[lo + a].flit));
    end
  endtask

  initial begin
    int         lat;
    logic       ack_save;

    // Packet A: head 0x80 followed by zero payload.
    for (int i = 0; i < 8; i++) begin
      tbl[i].flit     = (i == 0) ? 8'h80 : 8'h00;
      tbl[i].exp_req  = (i == 7);
      tbl[i].exp_chnl = 3'd0;
    end
    // Packet B: head 0x85, payload 0x11..0x17.
    for (int i = 0; i < 8; i++) begin
      tbl[8 + i].flit     = (i == 0) ? 8'h85 : 8'(8'h10 + i);
      tbl[8 + i].exp_req  = (i == 7);
      tbl[8 + i].exp_chnl = 3'd5;
    end
    // Partial packet D: 4 flits, which the reset interrupts.
    for (int i = 0; i < 4; i++) begin
      tbl[16 + i].flit     = (i == 0) ? 8'h83 : 8'(8'h30 + i);
      tbl[16 + i].exp_req  = 1'b0;
      tbl[16 + i].exp_chnl = 3'd3;
    end
    // Packet C, sent after the reset: head 0x82, payload 0x21..0x27.
    for (int i = 0; i < 8; i++) begin
      tbl[20 + i].flit     = (i == 0) ? 8'h82 : 8'(8'h20 + i);
      tbl[20 + i].exp_req  = (i == 7);
      tbl[20 + i].exp_chnl = 3'd2;
    end

    reset    = 1'b1;
    ch_req   = 1'b0;
    ch_flit  = 8'h00;
    sw_gnt   = 1'b0;
    buf_addr = 3'd0;
    tick();
    tick();
    check("rst_ch_ack", 32'(ch_ack), 32'd0);
    check("rst_sw_req", 32'(sw_req), 32'd0);
    check("rst_sw_chnl", 32'(sw_chnl), 32'd0);
    reset = 1'b0;
    tick();

    // Packet A, then read it back while in ARB.
    run_vecs(0, 7);
    read_buf(0, "A");

    // A ninth flit sent during ARB is held off until the grant completes.
    ack_save = ch_ack;
    ch_flit  = 8'h00;
    ch_req   = ~ch_req;
    for (int i = 0; i < 4; i++) tick();
    check("arb_no_ack", 32'(ch_ack), 32'(ack_save));
    sw_gnt = 1'b1;
    tick();
    tick();
    check("send_no_ack", 32'(ch_ack), 32'(ack_save));
    check("send_sw_req", 32'(sw_req), 32'd1);
    sw_gnt = 1'b0;
    tick();
    check("gnt_drop_sw_req", 32'(sw_req), 32'd0);
    check("gnt_drop_no_ack", 32'(ch_ack), 32'(ack_save));
    lat = 0;
    while ((ch_ack !== ch_req) && (lat < TIMEOUT)) begin
      tick();
      lat++;
    end
    check("idle_discard_ack", 32'(ch_ack), 32'(ch_req));
    tick();
    check("idle_discard_sw_req", 32'(sw_req), 32'd0);
    check("idle_discard_chnl", 32'(sw_chnl), 32'd0);

    // Packet B: grant, tx reads the buffer, then releases.
    run_vecs(8, 15);
    sw_gnt = 1'b1;
    tick();
    read_buf(8, "B");
    check("B_sw_req_send", 32'(sw_req), 32'd1);
    sw_gnt = 1'b0;
    tick();
    check("B_sw_req_drop", 32'(sw_req), 32'd0);

    // New packet D is accepted, then reset mid-packet after 4 flits.
    run_vecs(16, 19);
    reset  = 1'b1;
    ch_req = 1'b0;
    tick();
    check("midrst_ch_ack", 32'(ch_ack), 32'd0);
    check("midrst_sw_req", 32'(sw_req), 32'd0);
    check("midrst_sw_chnl", 32'(sw_chnl), 32'd0);
    reset = 1'b0;
    tick();

    // Packet C must land from address 0 after the reset.
    run_vecs(20, 27);
    read_buf(20, "C");
    sw_gnt = 1'b1;
    tick();
    sw_gnt = 1'b0;
    tick();
    check("C_sw_req_drop", 32'(sw_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
